// File: rtl/regfile_debug_scanner.sv
// regfile_debug_scanner
//   Walks the register file's debug read port from FIRST_REG for NUM_REGS
//   registers and streams each captured value as bytes over valid/ready.
//   Each record is an optional address tag {3'b000, addr}, followed by the
//   32-bit value MSB first.
//
// Ports
//   clock              system clock, posedge
//   reset              synchronous, active-high
//   start              one-cycle dump request (ignored unless idle)
//   abort              synchronous cancel, back to idle with no done pulse
//   read_address_debug registered debug read address to the register file
//   data_out_debug     debug read data, READ_LATENCY edges after the address
//   byte_out           current byte; held while byte_valid && !byte_ready
//   byte_valid         byte_out is valid
//   byte_ready         sink accepts byte_out at this edge
//   busy               dump in progress
//   done               one-cycle pulse after the last byte of the last record
module regfile_debug_scanner #(
  parameter int NUM_REGS     = 32,
  parameter int FIRST_REG    = 0,
  parameter int READ_LATENCY = 1,
  parameter int SEND_ADDR    = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic [4:0]  read_address_debug,
  input  logic [31:0] data_out_debug,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [5:0] FIRST_IDX = 6'(FIRST_REG);
  localparam logic [5:0] LAST_IDX  = 6'(FIRST_REG + NUM_REGS - 1);
  localparam logic [2:0] LAST_BYTE = (SEND_ADDR != 0) ? 3'd4 : 3'd3;
  localparam logic [1:0] WAIT_INIT = 2'(READ_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_SEND,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [5:0]  index;
  logic [5:0]  index_inc;
  logic [1:0]  wait_cnt;
  logic [2:0]  byte_cnt;
  logic [31:0] capture_p1;
  logic        last_byte;
  logic        capture_now;

  // Byte selection for a record: optional address tag, then MSB-first data.
  function automatic logic [7:0] select_byte(input logic [31:0] word,
                                             input logic [4:0]  addr,
                                             input logic [2:0]  cnt);
    logic [2:0] pos;
    logic [7:0] sel;
    pos = (SEND_ADDR != 0) ? (cnt - 3'd1) : cnt;
    case (pos)
      3'd0:    sel = word[31:24];
      3'd1:    sel = word[23:16];
      3'd2:    sel = word[15:8];
      default: sel = word[7:0];
    endcase
    if ((SEND_ADDR != 0) && (cnt == 3'd0)) sel = {3'b000, addr};
    return sel;
  endfunction

  assign index_inc   = index + 6'd1;
  assign last_byte   = (byte_cnt == LAST_BYTE);
  assign capture_now = (state == S_WAIT) && (wait_cnt == 2'd1);

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = S_ADDR;
      S_ADDR: state_next = S_WAIT;
      S_WAIT: if (wait_cnt == 2'd1) state_next = S_SEND;
      S_SEND: begin
        if (byte_ready && last_byte)
          state_next = (index == LAST_IDX) ? S_DONE : S_ADDR;
      end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (abort) state_next = S_IDLE;
  end

  // The address is launched on the edge that enters ADDR, so the ADDR cycle
  // already counts as the first cycle of read latency; the capture edge then
  // lands READ_LATENCY+1 edges after the address update.
  always_ff @(posedge clock) begin
    if (reset) begin
      index              <= 6'd0;
      wait_cnt           <= 2'd0;
      byte_cnt           <= 3'd0;
      read_address_debug <= 5'd0;
    end else if (abort) begin
      index    <= 6'd0;
      wait_cnt <= 2'd0;
      byte_cnt <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            index              <= FIRST_IDX;
            read_address_debug <= FIRST_IDX[4:0];
          end
        end
        S_ADDR: wait_cnt <= WAIT_INIT;
        S_WAIT: wait_cnt <= wait_cnt - 2'd1;
        S_SEND: begin
          if (byte_ready) begin
            if (last_byte) begin
              byte_cnt <= 3'd0;
              if (index != LAST_IDX) begin
                index              <= index_inc;
                read_address_debug <= index_inc[4:0];
              end
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ---- stage p1: captured register value, feeds the byte serializer ----
  always_ff @(posedge clock) begin
    if (capture_now) capture_p1 <= data_out_debug;
  end

  assign busy       = (state == S_ADDR) || (state == S_WAIT) || (state == S_SEND);
  assign byte_valid = (state == S_SEND);
  assign done       = (state == S_DONE);
  assign byte_out   = byte_valid ? select_byte(capture_p1, index[4:0], byte_cnt) : 8'h00;

endmodule

// File: tb/tb_regfile_debug_scanner.sv
// Bench for regfile_debug_scanner. Three instances:
//   0: defaults (32 regs from r0, latency 1, address tags)
//   1: SEND_ADDR=0, FIRST_REG=5, NUM_REGS=3
//   2: READ_LATENCY=2, otherwise defaults
// Expected bytes are queued when a dump is started and popped on each
// transfer; the register file is a shared array behind per-instance delay
// pipelines matching each instance's read latency.
module tb_regfile_debug_scanner;

  logic        clock = 1'b0;
  logic        rst_s   [3];
  logic        start_s [3];
  logic        abort_s [3];
  logic        rdy_s   [3];
  logic [4:0]  ra      [3];
  logic [31:0] rdat    [3];
  logic [31:0] rd2a;
  logic [7:0]  bo      [3];
  logic        bv      [3];
  logic        bsy     [3];
  logic        dn      [3];

  logic [31:0] rf [32];
  logic [7:0]  exp_q [3][$];

  int n_tests = 0;
  int n_fail  = 0;
  int xfer_cnt [3];
  int done_cnt [3];
  logic       prev_hold [3];
  logic [7:0] prev_bo   [3];

  int   edge_no = 0;
  logic [4:0] prev_ra2 = 5'd0;
  logic prev_bv2 = 1'b0;
  int   chg_edge = 0;
  logic chg_seen = 1'b0;

  always #5 clock = ~clock;

  regfile_debug_scanner dut0 (
    .clock(clock), .reset(rst_s[0]), .start(start_s[0]), .abort(abort_s[0]),
    .read_address_debug(ra[0]), .data_out_debug(rdat[0]),
    .byte_out(bo[0]), .byte_valid(bv[0]), .byte_ready(rdy_s[0]),
    .busy(bsy[0]), .done(dn[0]));

  regfile_debug_scanner #(.NUM_REGS(3), .FIRST_REG(5), .READ_LATENCY(1), .SEND_ADDR(0)) dut1 (
    .clock(clock), .reset(rst_s[1]), .start(start_s[1]), .abort(abort_s[1]),
    .read_address_debug(ra[1]), .data_out_debug(rdat[1]),
    .byte_out(bo[1]), .byte_valid(bv[1]), .byte_ready(rdy_s[1]),
    .busy(bsy[1]), .done(dn[1]));

  regfile_debug_scanner #(.READ_LATENCY(2)) dut2 (
    .clock(clock), .reset(rst_s[2]), .start(start_s[2]), .abort(abort_s[2]),
    .read_address_debug(ra[2]), .data_out_debug(rdat[2]),
    .byte_out(bo[2]), .byte_valid(bv[2]), .byte_ready(rdy_s[2]),
    .busy(bsy[2]), .done(dn[2]));

  // Register file debug read models: 1, 1 and 2 edges of latency.
  always @(posedge clock) begin
    rdat[0] <= rf[ra[0]];
    rdat[1] <= rf[ra[1]];
    rd2a    <= rf[ra[2]];
    rdat[2] <= rd2a;
    edge_no <= edge_no + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard pop on transfer, hold-stability and done/transfer counting.
  always @(negedge clock) begin
    for (int d = 0; d < 3; d++) begin
      logic       xfer;
      logic [8:0] e;
      xfer = bv[d] && rdy_s[d] && !abort_s[d] && !rst_s[d];
      if (xfer) begin
        if (exp_q[d].size() == 0) e = 9'h100;
        else                      e = {1'b0, exp_q[d].pop_front()};
        check($sformatf("byte%0d", d), {1'b0, bo[d]}, e);
        xfer_cnt[d] <= xfer_cnt[d] + 1;
      end
      if (prev_hold[d]) begin
        check($sformatf("hold_valid%0d", d), bv[d], 1'b1);
        check($sformatf("hold_byte%0d", d), bo[d], prev_bo[d]);
      end
      prev_hold[d] <= bv[d] && !rdy_s[d] && !abort_s[d] && !rst_s[d];
      prev_bo[d]   <= bo[d];
      if (dn[d]) done_cnt[d] <= done_cnt[d] + 1;
    end
  end

  // Address-to-capture spacing for the latency-2 instance: the first byte of
  // a record is presented right after the capture edge.
  always @(negedge clock) begin
    if (ra[2] != prev_ra2) begin
      chg_edge <= edge_no;
      chg_seen <= 1'b1;
    end
    if (bv[2] && !prev_bv2) begin
      if (chg_seen) check("rd_latency", 64'(edge_no - chg_edge), 64'd3);
      chg_seen <= 1'b0;
    end
    prev_ra2 <= ra[2];
    prev_bv2 <= bv[2];
  end

  task automatic push_dump(input int d, input int first, input int num, input bit tag);
    logic [31:0] w;
    for (int r = first; r < first + num; r++) begin
      w = rf[r];
      if (tag) exp_q[d].push_back({3'b000, 5'(r)});
      exp_q[d].push_back(w[31:24]);
      exp_q[d].push_back(w[23:16]);
      exp_q[d].push_back(w[15:8]);
      exp_q[d].push_back(w[7:0]);
    end
  endtask

  // Called at #2 after a posedge. Pulses start, then runs until done is seen.
  // cyc is the cycle index (1 = cycle after the start edge) where done is high.
  task automatic run_dump(input int d, input bit rnd, input int budget,
                          input int extra_start_at, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc = 0;
    start_s[d] = 1'b1;
    for (int i = 1; i <= budget && !seen; i++) begin
      @(posedge clock); #2;
      start_s[d] = 1'b0;
      if (i == extra_start_at) start_s[d] = 1'b1;
      rdy_s[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (dn[d]) begin
        seen = 1'b1;
        cyc = i;
      end
    end
    start_s[d] = 1'b0;
    rdy_s[d] = 1'b1;
    check($sformatf("done_seen%0d", d), seen, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #2;
    end
  endtask

  initial begin
    int cyc;
    int dc0;
    int base;
    bit hit;

    for (int i = 0; i < 32; i++) rf[i] = 32'h11111111 * 32'(i % 16);
    for (int d = 0; d < 3; d++) begin
      rst_s[d] = 1'b1; start_s[d] = 1'b0; abort_s[d] = 1'b0; rdy_s[d] = 1'b1;
    end
    repeat (3) @(posedge clock);
    #2;
    for (int d = 0; d < 3; d++) rst_s[d] = 1'b0;

    // Reset state
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_addr%0d", d), ra[d], 5'd0);
      check($sformatf("rst_byte%0d", d), bo[d], 8'h00);
      check($sformatf("rst_valid%0d", d), bv[d], 1'b0);
      check($sformatf("rst_busy%0d", d), bsy[d], 1'b0);
      check($sformatf("rst_done%0d", d), dn[d], 1'b0);
    end
    idle(2);

    // Full default dump, sink always ready
    dc0 = done_cnt[0];
    push_dump(0, 0, 32, 1'b1);
    run_dump(0, 1'b0, 400, 0, cyc);
    check("done_cycle", 64'(cyc), 64'd225);
    check("done_busy_low", bsy[0], 1'b0);
    idle(3);
    check("done_once", 64'(done_cnt[0] - dc0), 64'd1);
    check("sb_left_full", 64'(exp_q[0].size()), 64'd0);

    // Same dump with a random sink
    dc0 = done_cnt[0];
    push_dump(0, 0, 32, 1'b1);
    run_dump(0, 1'b1, 3000, 0, cyc);
    idle(3);
    check("done_once_rnd", 64'(done_cnt[0] - dc0), 64'd1);
    check("sb_left_rnd", 64'(exp_q[0].size()), 64'd0);

    // Abort while register 3's second data byte is presented
    dc0 = done_cnt[0];
    base = xfer_cnt[0];
    push_dump(0, 0, 4, 1'b1);
    hit = 1'b0;
    start_s[0] = 1'b1;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(posedge clock); #2;
      start_s[0] = 1'b0;
      if (xfer_cnt[0] - base == 17) hit = 1'b1;
    end
    check("abort_reach", hit, 1'b1);
    check("abort_byte", bo[0], 8'h33);
    abort_s[0] = 1'b1;
    @(posedge clock); #2;
    abort_s[0] = 1'b0;
    check("abort_valid", bv[0], 1'b0);
    check("abort_busy", bsy[0], 1'b0);
    check("abort_byteout", bo[0], 8'h00);
    check("abort_addr_hold", ra[0], 5'd3);
    check("abort_unsent", 64'(exp_q[0].size()), 64'd3);
    exp_q[0].delete();
    idle(4);
    check("abort_no_done", 64'(done_cnt[0] - dc0), 64'd0);
    push_dump(0, 0, 32, 1'b1);
    run_dump(0, 1'b0, 400, 0, cyc);
    check("restart_cycle", 64'(cyc), 64'd225);
    idle(2);
    check("sb_left_restart", 64'(exp_q[0].size()), 64'd0);

    // Reset during WAIT, then a dump with an extra start while busy
    dc0 = done_cnt[0];
    start_s[0] = 1'b1;
    @(posedge clock); #2;
    start_s[0] = 1'b0;
    @(posedge clock); #2;
    check("wait_busy", bsy[0], 1'b1);
    check("wait_valid", bv[0], 1'b0);
    rst_s[0] = 1'b1;
    @(posedge clock); #2;
    rst_s[0] = 1'b0;
    check("mid_rst_addr", ra[0], 5'd0);
    check("mid_rst_busy", bsy[0], 1'b0);
    check("mid_rst_valid", bv[0], 1'b0);
    check("mid_rst_byte", bo[0], 8'h00);
    idle(4);
    check("mid_rst_no_done", 64'(done_cnt[0] - dc0), 64'd0);
    push_dump(0, 0, 32, 1'b1);
    run_dump(0, 1'b0, 400, 40, cyc);
    check("extra_start_cycle", 64'(cyc), 64'd225);
    idle(20);
    check("extra_start_busy", bsy[0], 1'b0);
    check("extra_start_done", 64'(done_cnt[0] - dc0), 64'd1);
    check("sb_left_extra", 64'(exp_q[0].size()), 64'd0);

    // Latency-2 instance with a random sink
    push_dump(2, 0, 32, 1'b1);
    run_dump(2, 1'b1, 3000, 0, cyc);
    idle(2);
    check("sb_left_rl2", 64'(exp_q[2].size()), 64'd0);

    // Untagged window r5..r7, start during DONE ignored
    rf[5] = 32'hDEADBEEF;
    rf[6] = 32'h01234567;
    rf[7] = 32'h80000001;
    dc0 = done_cnt[1];
    push_dump(1, 5, 3, 1'b0);
    run_dump(1, 1'b0, 100, 0, cyc);
    check("win_cycle", 64'(cyc), 64'd19);
    start_s[1] = 1'b1;
    @(posedge clock); #2;
    start_s[1] = 1'b0;
    check("done_start_ignored", bsy[1], 1'b0);
    idle(2);
    check("done_start_idle", bsy[1], 1'b0);
    check("win_done_once", 64'(done_cnt[1] - dc0), 64'd1);
    check("sb_left_win", 64'(exp_q[1].size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_debug_scanner.md
Name: regfile_debug_scanner

Overview:
- Master for the register file's debug read port: on a start pulse, walks the debug read address across the register file and reads each register.
- Captures each value and serializes it onto a valid/ready byte stream, normally feeding the UART transmitter, for host-side register dumps.
- Sits beside the core on the main clock. The register file's debug clock input is tied to the same clock.

Parameters:
- NUM_REGS, 32, number of registers dumped, starting at address FIRST_REG; legal 1..32.
- FIRST_REG, 0, first register address dumped; FIRST_REG+NUM_REGS must be <= 32.
- READ_LATENCY, 1, clock edges from read_address_debug change to valid data_out_debug; legal 1..3.
- SEND_ADDR, 1, when 1 each record is preceded by a one-byte address tag {3'b000, addr}.

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a dump; ignored while busy.
- abort  input  1  synchronous cancel; returns to IDLE at the next edge with no done pulse.
- read_address_debug  output  5  debug read address to the register file; registered.
- data_out_debug  input  32  debug read data from the register file.
- byte_out  output  8  serialized byte.
- byte_valid  output  1  byte_out is valid.
- byte_ready  input  1  sink accepts byte_out this cycle.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse after the final byte of the final register transfers.

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset).
- Reset values: read_address_debug=0, byte_out=0, byte_valid=0, busy=0, done=0; state IDLE; counters 0.
- Reset mid-operation: byte_valid drops at that edge and the dump is abandoned; no done pulse.
- IDLE
  - start=1 -> ADDR; busy=1 from the next cycle.
  - Register index = FIRST_REG.
- ADDR
  - read_address_debug <= current index.
  - Wait counter <= READ_LATENCY.
  - -> WAIT.
- WAIT
  - Decrement the wait counter each cycle.
  - When it reaches 0, data_out_debug is latched into a 32-bit capture register -> SEND.
  - Capture happens exactly READ_LATENCY+1 edges after the edge that updated read_address_debug.
- SEND
  - Emits SEND_ADDR ? 5 : 4 bytes in order: optional tag, then data[31:24], [23:16], [15:8], [7:0] (MSB first).
  - byte_valid is asserted and held until byte_ready=1 at a clock edge (transfer).
  - byte_out must not change while byte_valid=1 and byte_ready=0.
  - After a transfer, the next byte is presented in the following cycle. byte_valid may stay high continuously, giving back-to-back bytes when byte_ready is held high.
  - On transfer of the last byte of a record: if index == FIRST_REG+NUM_REGS-1 -> DONE, else index+1 -> ADDR.
- DONE
  - done=1 for one cycle, busy=0 in the same cycle.
  - byte_valid=0.
  - -> IDLE.
  - start sampled during DONE is ignored.
- Snapshot semantics
  - Each register is captured individually; the dump is not atomic.
  - A core write to register k after k is captured does not affect the bytes sent for k.
  - A write to a not-yet-scanned register is reflected in its record.
- Index arithmetic: 6 bits internally, so FIRST_REG+NUM_REGS=32 does not wrap. read_address_debug takes the low 5 bits.
- Abort:
  - Takes effect at the edge where it is sampled high, in any state.
  - Outputs go to reset values except read_address_debug, which holds its value.
  - No done pulse.
  - Abort has priority over start and over byte_ready in the same cycle; a byte presented that cycle counts as not transferred.
- Throughput with byte_ready held at 1 and SEND_ADDR=1: 1 (ADDR) + READ_LATENCY (WAIT) + 5 (SEND) cycles per register. Defaults give 7*32 = 224 cycles, plus 1 DONE cycle.

Test Plan:
- Load r[i]=0x11111111*(i%16) for i=1..31 (r0=0), byte_ready=1, pulse start -> 160 bytes: 0x00,00,00,00,00; 0x01,11,11,11,11; ...; 0x1F,FF,FF,FF,FF. done pulses once, 225 cycles after start.
- Same dump with byte_ready toggled in a pseudo-random pattern -> identical byte sequence; byte_out stable whenever byte_valid=1 and byte_ready=0; no byte lost or duplicated.
- SEND_ADDR=0, FIRST_REG=5, NUM_REGS=3, r5=0xDEADBEEF, r6=0x01234567, r7=0x80000001 -> 12 bytes DE AD BE EF 01 23 45 67 80 00 00 01, then done.
- READ_LATENCY=2, with a register-file model delayed by 2 edges -> correct values; read_address_debug changes exactly 3 edges before each capture.
- Assert abort while sending register 3's second data byte -> byte_valid=0 and busy=0 next cycle, no done. A new start then dumps from FIRST_REG.
- Assert reset during WAIT, and separately pulse start while busy -> reset returns all outputs to zero at the next edge with no done. The extra start is ignored and exactly one dump completes.
